// File: rtl/rvc_pkg.sv
// Shared RV32C encodings and types for the fetch aligner and format expanders.
// Pure declarations; no timing.
// No flow control of its own.
package rvc_pkg;

    typedef logic [15:0] halfword_t;
    typedef logic [31:0] instr_t;

    typedef enum logic [1:0] {
        Q0     = 2'b00,
        Q1     = 2'b01,
        Q2     = 2'b10,
        Q3_32B = 2'b11
    } quadrant_t;

    localparam logic [3:0] C_FUNCT4_JR_MV    = 4'b1000;
    localparam logic [3:0] C_FUNCT4_JALR_ADD = 4'b1001;

    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam instr_t     EBREAK  = 32'h00100073;

endpackage

// File: rtl/rvc_cr_expand.sv
// Expands CR-format compressed halfwords; anything else passes through zero-extended.
// Purely combinational, zero cycles.
// No flow control; the caller qualifies the result with its own valid.
module rvc_cr_expand
    import rvc_pkg::*;
(
    input  halfword_t half,
    output instr_t    instr,
    output logic      expanded,
    output logic      illegal
);

    logic [4:0] rs1;
    logic [4:0] rs2;

    assign rs1 = half[11:7];
    assign rs2 = half[6:2];

    always_comb begin
        instr    = {16'b0, half};
        expanded = 1'b0;
        illegal  = (half == 16'h0000);
        if (quadrant_t'(half[1:0]) == Q2) begin
            case (half[15:12])
                C_FUNCT4_JR_MV: begin
                    if (rs2 != 5'd0) begin
                        instr    = {7'b0, rs2, 5'd0, 3'b000, rs1, OP_REG};
                        expanded = 1'b1;
                    end else if (rs1 != 5'd0) begin
                        instr    = {12'b0, rs1, 3'b000, 5'd0, OP_JALR};
                        expanded = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                C_FUNCT4_JALR_ADD: begin
                    expanded = 1'b1;
                    if (rs2 != 5'd0)
                        instr = {7'b0, rs2, rs1, 3'b000, rs1, OP_REG};
                    else if (rs1 != 5'd0)
                        instr = {12'b0, rs1, 3'b000, 5'd1, OP_JALR};
                    else
                        instr = EBREAK;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Halfword realignment buffer: fetch words in, one 16/32-bit instruction with PC out.
// A word accepted at edge N is presentable in cycle N+1; decode is combinational off the head.
// Fetch ready comes from registered occupancy only; the consumer may stall indefinitely.
module rvc_fetch_aligner
    import rvc_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int DEPTH_HW = 4
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iFLUSH,
    input  logic [PC_W-1:0] iFLUSH_PC,
    input  logic            iFETCH_VALID,
    output logic            oFETCH_READY,
    input  logic [31:0]     iFETCH_DATA,
    input  logic [PC_W-1:0] iFETCH_PC,
    output logic            oINSTR_VALID,
    input  logic            iINSTR_READY,
    output logic [31:0]     oINSTR,
    output logic [PC_W-1:0] oINSTR_PC,
    output logic            oIS_C,
    output logic            oEXPANDED,
    output logic            oILLEGAL
);

    localparam int AW = $clog2(DEPTH_HW);
    localparam int CW = $clog2(DEPTH_HW + 1);

    halfword_t       hwBuf [DEPTH_HW];
    logic [AW-1:0]   headPtr, tailPtr;
    logic [CW-1:0]   count;
    logic            skipLo;
    logic [PC_W-1:0] headPc;

    halfword_t hLo, hHi;
    logic      is32;
    logic      pushFire, popFire;
    logic [CW-1:0] pushAmt, popAmt;
    instr_t    crInstr;
    logic      crExpanded, crIllegal;

    assign hLo  = hwBuf[headPtr];
    assign hHi  = hwBuf[headPtr + AW'(1)];
    assign is32 = (hLo[1:0] == 2'b11);

    assign oFETCH_READY = !iRST && (count <= CW'(DEPTH_HW - 2));
    // A 32-bit instruction whose upper half has not arrived yet must wait.
    assign oINSTR_VALID = !iRST && (((count >= CW'(1)) && !is32) || (count >= CW'(2)));

    assign pushFire = iFETCH_VALID && oFETCH_READY;
    assign popFire  = oINSTR_VALID && iINSTR_READY;

    always_comb begin
        pushAmt = '0;
        popAmt  = '0;
        if (pushFire)
            pushAmt = skipLo ? CW'(1) : CW'(2);
        if (popFire)
            popAmt = is32 ? CW'(2) : CW'(1);
    end

    rvc_cr_expand u_crExpand (
        .half     (hLo),
        .instr    (crInstr),
        .expanded (crExpanded),
        .illegal  (crIllegal)
    );

    assign oINSTR    = is32 ? {hHi, hLo} : crInstr;
    assign oINSTR_PC = headPc;
    assign oIS_C     = oINSTR_VALID && !is32;
    assign oEXPANDED = oIS_C && crExpanded;
    assign oILLEGAL  = oIS_C && crIllegal;

    always_ff @(posedge iCLK) begin
        if (pushFire && !iFLUSH) begin
            if (skipLo) begin
                hwBuf[tailPtr] <= iFETCH_DATA[31:16];
            end else begin
                hwBuf[tailPtr]          <= iFETCH_DATA[15:0];
                hwBuf[tailPtr + AW'(1)] <= iFETCH_DATA[31:16];
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            count   <= '0;
            headPtr <= '0;
            tailPtr <= '0;
            skipLo  <= 1'b0;
            headPc  <= '0;
        end else if (iFLUSH) begin
            count   <= '0;
            headPtr <= '0;
            tailPtr <= '0;
            skipLo  <= iFLUSH_PC[1];
            headPc  <= iFLUSH_PC & ~PC_W'(1);
        end else begin
            count <= count + pushAmt - popAmt;
            if (pushFire) begin
                tailPtr <= tailPtr + AW'(pushAmt);
                skipLo  <= 1'b0;
            end
            if (popFire) begin
                headPtr <= headPtr + AW'(popAmt);
                headPc  <= headPc + (is32 ? PC_W'(4) : PC_W'(2));
            end
            // Pop is impossible from empty, so this never races the advance above.
            if (pushFire && (count == '0))
                headPc <= skipLo ? iFETCH_PC + PC_W'(2) : iFETCH_PC;
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed bench for rvc_fetch_aligner: decode table plus straddle, skip, backpressure,
// reset and flush sequences.
module tb_rvc_fetch_aligner;

    logic        iCLK = 1'b0;
    logic        iRST, iFLUSH, iFETCH_VALID, iINSTR_READY;
    logic [31:0] iFLUSH_PC, iFETCH_DATA, iFETCH_PC;
    logic        oFETCH_READY, oINSTR_VALID, oIS_C, oEXPANDED, oILLEGAL;
    logic [31:0] oINSTR, oINSTR_PC;

    int nChecks = 0;
    int nFail   = 0;

    always #5 iCLK = ~iCLK;

    rvc_fetch_aligner #(.PC_W(32), .DEPTH_HW(4)) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iFLUSH       (iFLUSH),
        .iFLUSH_PC    (iFLUSH_PC),
        .iFETCH_VALID (iFETCH_VALID),
        .oFETCH_READY (oFETCH_READY),
        .iFETCH_DATA  (iFETCH_DATA),
        .iFETCH_PC    (iFETCH_PC),
        .oINSTR_VALID (oINSTR_VALID),
        .iINSTR_READY (iINSTR_READY),
        .oINSTR       (oINSTR),
        .oINSTR_PC    (oINSTR_PC),
        .oIS_C        (oIS_C),
        .oEXPANDED    (oEXPANDED),
        .oILLEGAL     (oILLEGAL)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        int          n;
        logic [31:0] i0;
        logic [2:0]  f0;   // {isC, expanded, illegal}
        logic [31:0] i1;
        logic [2:0]  f1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic doFlush(input logic [31:0] pc);
        iFLUSH    = 1'b1;
        iFLUSH_PC = pc;
        step();
        iFLUSH = 1'b0;
    endtask

    task automatic pushWord(input logic [31:0] w, input logic [31:0] pc);
        int t;
        iFETCH_VALID = 1'b1;
        iFETCH_DATA  = w;
        iFETCH_PC    = pc;
        t = 0;
        while (!oFETCH_READY && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) chk("push_timeout", 0, 1);
        step();
        iFETCH_VALID = 1'b0;
    endtask

    task automatic popCheck(input string name, input logic [31:0] expI, input logic [31:0] expPc,
                            input logic [2:0] expF);
        int t;
        t = 0;
        while (!oINSTR_VALID && t < 20) begin
            step();
            t++;
        end
        chk({name, "_valid"}, oINSTR_VALID, 1);
        chk({name, "_instr"}, oINSTR, expI);
        chk({name, "_pc"}, oINSTR_PC, expPc);
        chk({name, "_flags"}, {oIS_C, oEXPANDED, oILLEGAL}, expF);
        iINSTR_READY = 1'b1;
        step();
        iINSTR_READY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bpWords[3];
        int accepted;

        vecs[0] = '{32'h0002_9082, 32'h100, 2, 32'h000080E7, 3'b110, 32'h00000002, 3'b100};
        vecs[1] = '{32'h8002_8282, 32'h110, 2, 32'h00028067, 3'b110, 32'h00008002, 3'b101};
        vecs[2] = '{32'h0000_9002, 32'h120, 2, 32'h00100073, 3'b110, 32'h00000000, 3'b101};
        vecs[3] = '{32'h9522_852E, 32'h130, 2, 32'h00B00533, 3'b110, 32'h00850533, 3'b110};
        vecs[4] = '{32'h4501_0001, 32'h140, 2, 32'h00000001, 3'b100, 32'h00004501, 3'b100};
        vecs[5] = '{32'h00A0_0093, 32'h150, 1, 32'h00A00093, 3'b000, 32'h0, 3'b000};

        iRST = 1'b1; iFLUSH = 1'b0; iFLUSH_PC = '0; iFETCH_VALID = 1'b0;
        iFETCH_DATA = '0; iFETCH_PC = '0; iINSTR_READY = 1'b0;
        step();
        step();
        chk("rst_fetch_ready", oFETCH_READY, 0);
        chk("rst_instr_valid", oINSTR_VALID, 0);
        chk("rst_flags", {oIS_C, oEXPANDED, oILLEGAL}, 3'b000);
        chk("rst_pc", oINSTR_PC, 0);
        iRST = 1'b0;
        #1;
        chk("post_rst_ready", oFETCH_READY, 1);

        for (int v = 0; v < 6; v++) begin
            doFlush(vecs[v].pc);
            pushWord(vecs[v].word, vecs[v].pc);
            chk($sformatf("v%0d_latency", v), oINSTR_VALID, 1);
            popCheck($sformatf("v%0d_i0", v), vecs[v].i0, vecs[v].pc, vecs[v].f0);
            if (vecs[v].n == 2)
                popCheck($sformatf("v%0d_i1", v), vecs[v].i1, vecs[v].pc + 2, vecs[v].f1);
            chk($sformatf("v%0d_drained", v), oINSTR_VALID, 0);
        end

        // 32-bit instruction straddling two fetch words
        doFlush(32'h200);
        pushWord(32'h0013_8082, 32'h200);
        popCheck("strad_jr", 32'h00008067, 32'h200, 3'b110);
        chk("strad_wait", oINSTR_VALID, 0);
        pushWord(32'h0000_0000, 32'h204);
        chk("strad_valid", oINSTR_VALID, 1);
        popCheck("strad_32b", 32'h00000013, 32'h202, 3'b000);
        popCheck("strad_tail", 32'h00000000, 32'h206, 3'b101);

        // Redirect into the upper half of a word
        doFlush(32'h302);
        pushWord(32'h9522_4501, 32'h300);
        popCheck("skip_add", 32'h00850533, 32'h302, 3'b110);
        chk("skip_drained", oINSTR_VALID, 0);

        // Backpressure: consumer stalled while fetch keeps offering
        bpWords[0] = 32'h4505_4501;
        bpWords[1] = 32'h450D_4509;
        bpWords[2] = 32'h4515_4511;
        doFlush(32'h400);
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            iFETCH_VALID = 1'b1;
            iFETCH_DATA  = bpWords[accepted];
            iFETCH_PC    = 32'h400 + 32'(4 * accepted);
            if (c > 0) begin
                chk($sformatf("bp_hold_instr%0d", c), oINSTR, 32'h00004501);
                chk($sformatf("bp_hold_pc%0d", c), oINSTR_PC, 32'h400);
            end
            if (oFETCH_READY) accepted++;
            step();
        end
        iFETCH_VALID = 1'b0;
        chk("bp_accepted", accepted, 2);
        chk("bp_full_ready", oFETCH_READY, 0);
        iINSTR_READY = 1'b1;
        step();
        iINSTR_READY = 1'b0;
        chk("bp_cnt3_ready", oFETCH_READY, 0);
        popCheck("bp_i1", 32'h00004505, 32'h402, 3'b100);
        chk("bp_cnt2_ready", oFETCH_READY, 1);
        popCheck("bp_i2", 32'h00004509, 32'h404, 3'b100);
        popCheck("bp_i3", 32'h0000450D, 32'h406, 3'b100);
        chk("bp_drained", oINSTR_VALID, 0);

        // Reset with three halfwords buffered
        doFlush(32'h502);
        pushWord(32'h4505_0000, 32'h500);
        pushWord(32'h450D_4509, 32'h504);
        chk("mid_valid", oINSTR_VALID, 1);
        chk("mid_instr", oINSTR, 32'h00004505);
        chk("mid_pc", oINSTR_PC, 32'h502);
        iRST = 1'b1;
        #1;
        chk("mid_rst_valid", oINSTR_VALID, 0);
        chk("mid_rst_ready", oFETCH_READY, 0);
        step();
        iRST = 1'b0;
        #1;
        chk("after_rst_valid", oINSTR_VALID, 0);
        chk("after_rst_ready", oFETCH_READY, 1);

        // Flush and push in the same cycle: word is dropped
        iFLUSH       = 1'b1;
        iFLUSH_PC    = 32'h600;
        iFETCH_VALID = 1'b1;
        iFETCH_DATA  = 32'h8282_8282;
        iFETCH_PC    = 32'h700;
        step();
        iFLUSH       = 1'b0;
        iFETCH_VALID = 1'b0;
        chk("flushpush_valid", oINSTR_VALID, 0);
        pushWord(32'h4505_4501, 32'h600);
        popCheck("flushpush_i0", 32'h00004501, 32'h600, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
